watch_set_ctrl: RTL and testbench
=================================

Name: watch_set_ctrl

Overview:
Controller for the BCD time-of-day counter (seconds/minutes/hours digits). It generates the 1 Hz count enable in normal running. It also sequences a two-field time-setting mode (hours, then minutes) from two pre-debounced button pulses. On exit it loads the edited value into the counter.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count tick (>=2)
BLINK_DIV, 12_500_000, clk cycles per blink half-period (used only with BLINK_EN)

Ports:
clk  input  1  system clock
a_reset  input  1  asynchronous reset, active-high
mode_p  input  1  single-cycle pulse; advances mode
inc_p  input  1  single-cycle pulse; increments selected field
cur_h_t, cur_h_o, cur_m_t, cur_m_o  input  4 each  current BCD digits from time counter
tick  output  1  one-cycle count enable to time counter
ld  output  1  one-cycle load strobe; counter loads ld_* and clears seconds digits
ld_h_t, ld_h_o, ld_m_t, ld_m_o  output  4 each  BCD load value, valid when ld=1
edit  output  1  high in SET_H/SET_M
sel  output  2  0 none, 1 hours, 2 minutes
blink  output  1  display-blank request for selected field

Behaviour:
- Reset (async, a_reset=1):
  - state=RUN, prescaler=0, edit registers=00:00.
  - tick=ld=edit=blink=0, sel=0, ld_*=0.
- States RUN, SET_H, SET_M, COMMIT; all outputs decoded from registered state and registers.
- RUN:
  - prescaler counts 0..TICK_DIV-1 and wraps.
  - tick=1 exactly when prescaler==TICK_DIV-1, i.e. once per TICK_DIV cycles.
  - inc_p is ignored.
  - mode_p: capture cur_* into edit registers, go to SET_H, prescaler<=0.
  - A tick coinciding with mode_p still asserts that cycle.
- Capture normalisation:
  - hours >23 or any non-BCD hour digit -> 00.
  - minutes >59 or any non-BCD minute digit -> 00.
- SET_H (sel=1):
  - inc_p: 23->00; x9->(x+1)0; else ones+1.
  - mode_p -> SET_M.
- SET_M (sel=2):
  - inc_p: 59->00; x9->(x+1)0; else ones+1.
  - mode_p -> COMMIT.
- In SET_H/SET_M: prescaler held 0, tick=0, edit=1.
- COMMIT (one cycle):
  - ld=1 and ld_*=edit registers.
  - mode_p/inc_p ignored.
  - Next state RUN with prescaler=0.
  - First tick after commit is the TICK_DIV-th RUN cycle.
- ld_* hold their last loaded value outside COMMIT.
- mode_p and inc_p in the same cycle: mode_p wins, inc is dropped.
- Latency:
  - mode_p sampled in cycle n takes effect in cycle n+1; inc_p likewise.
  - ld is high in cycle n+1 after the final mode_p.
- Reset mid-edit: edit values are discarded and no ld is issued.

Optional Feature:
BLINK_EN:
- Defined:
  - A blink counter runs 0..BLINK_DIV-1 only in SET_H/SET_M; blink toggles at each wrap.
  - On entry to SET_H or SET_M, blink=0 and the counter=0.
  - Any inc_p restarts the counter and forces blink=0, so the field stays visible while adjusting.
  - blink=0 in RUN/COMMIT.
- Undefined: blink tied 0; no blink counter logic.

Decomposition:
- Package watch_pkg:
  - typedef bcd_t (logic [3:0]).
  - enum ctrl_state_t {RUN, SET_H, SET_M, COMMIT}.
  - Constants HOUR_T_MAX=2, HOUR_O_WRAP=3, MIN_T_MAX=5, DIGIT_MAX=9.
  - sel encodings SEL_NONE/SEL_HOURS/SEL_MIN.
- Sub-module bcd2_inc: combinational two-digit BCD increment with wrap, parameterised by tens/ones wrap point. Instantiated twice (hours 23, minutes 59); also supplies the range check used by capture normalisation.

Test Plan:
1. TICK_DIV=10, release reset, run 35 cycles -> tick pulses on cycles 10, 20, 30 only; ld=0, edit=0.
2. cur=19:58, mode_p, 5x inc_p, mode_p, 3x inc_p, mode_p -> ld one cycle with 00:01 (19->23->00; 58->59->00->01); sel sequence 1,2,0; next tick 10 cycles after COMMIT.
3. cur=2A:77 (invalid), mode_p, mode_p, mode_p -> ld with 00:00.
4. In SET_H, mode_p and inc_p same cycle -> enters SET_M, hours unchanged; inc_p in RUN -> no state change.
5. Assert a_reset during SET_M with edited 12:34 -> outputs reset immediately, no ld, state RUN, tick resumes after 10 cycles.
6. BLINK_EN, BLINK_DIV=4, in SET_H -> blink toggles every 4 cycles; inc_p forces blink=0 and restarts the period; blink=0 after COMMIT.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting controller.
//   bcd_t        : one BCD digit
//   ctrl_state_t : controller states RUN / SET_H / SET_M / COMMIT
//   sel_t        : field-select encoding (none / hours / minutes)
//   HOUR_*/MIN_* : wrap points of the two editable fields (23 and 59)
//   is_bcd()     : true when a nibble is a legal decimal digit
package watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } ctrl_state_t;

  typedef logic [1:0] sel_t;

  localparam bcd_t HOUR_T_MAX  = 4'd2;
  localparam bcd_t HOUR_O_WRAP = 4'd3;
  localparam bcd_t MIN_T_MAX   = 4'd5;
  localparam bcd_t DIGIT_MAX   = 4'd9;

  localparam sel_t SEL_NONE  = 2'd0;
  localparam sel_t SEL_HOURS = 2'd1;
  localparam sel_t SEL_MIN   = 2'd2;

  function automatic logic is_bcd(input bcd_t d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/watch_set_ctrl_if.sv
// Bus between the time-setting controller and its surroundings
// (buttons, BCD time counter, display).
//   mode_p, inc_p        : debounced single-cycle button pulses
//   cur_h_t..cur_m_o     : current BCD time from the counter
//   tick                 : one-cycle count enable to the counter
//   ld, ld_h_t..ld_m_o   : load strobe and value for the counter
//   edit, sel, blink     : display hints while setting
// Modports: master = controller side, slave = counter/button/display side.
interface watch_set_ctrl_if;
  import watch_pkg::*;

  logic mode_p;
  logic inc_p;
  bcd_t cur_h_t;
  bcd_t cur_h_o;
  bcd_t cur_m_t;
  bcd_t cur_m_o;
  logic tick;
  logic ld;
  bcd_t ld_h_t;
  bcd_t ld_h_o;
  bcd_t ld_m_t;
  bcd_t ld_m_o;
  logic edit;
  sel_t sel;
  logic blink;

  modport master (
    input  mode_p, inc_p, cur_h_t, cur_h_o, cur_m_t, cur_m_o,
    output tick, ld, ld_h_t, ld_h_o, ld_m_t, ld_m_o, edit, sel, blink
  );

  modport slave (
    output mode_p, inc_p, cur_h_t, cur_h_o, cur_m_t, cur_m_o,
    input  tick, ld, ld_h_t, ld_h_o, ld_m_t, ld_m_o, edit, sel, blink
  );

endinterface

// File: rtl/watch_set_ctrl_bcd2_inc.sv
// Combinational two-digit BCD incrementer with wrap to 00.
// The wrap point is T_MAX:O_WRAP (23 for hours, 59 for minutes).
// Ports:
//   i_t, i_o : tens / ones digit in
//   o_t, o_o : incremented tens / ones digit
//   o_valid  : input is a legal value (both digits BCD, not above wrap point)
module bcd2_inc
  import watch_pkg::*;
#(
  parameter bcd_t T_MAX  = HOUR_T_MAX,
  parameter bcd_t O_WRAP = HOUR_O_WRAP
) (
  input  bcd_t i_t,
  input  bcd_t i_o,
  output bcd_t o_t,
  output bcd_t o_o,
  output logic o_valid
);

  always_comb begin
    o_t = i_t;
    o_o = i_o + 4'd1;
    if ((i_t == T_MAX) && (i_o == O_WRAP)) begin
      o_t = '0;
      o_o = '0;
    end else if (i_o == DIGIT_MAX) begin
      o_t = i_t + 4'd1;
      o_o = '0;
    end
  end

  // Tens above T_MAX is out of range regardless of ones, which also
  // rejects non-BCD tens digits since T_MAX < 9.
  assign o_valid = is_bcd(i_o) &&
                   ((i_t < T_MAX) || ((i_t == T_MAX) && (i_o <= O_WRAP)));

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-of-day controller: produces the count tick while running and
// sequences hours-then-minutes editing from the mode/inc buttons, finally
// loading the edited time into the BCD counter with a one-cycle strobe.
// Ports:
//   clk     : system clock
//   a_reset : asynchronous reset, active-high
//   bus     : watch_set_ctrl_if.master (buttons, current time, tick,
//             load strobe/value, edit/sel/blink display hints)
// Parameters:
//   TICK_DIV  : clk cycles per count tick (>= 2)
//   BLINK_DIV : clk cycles per blink half-period (only with BLINK_EN)
// Build option: define BLINK_EN to blink the selected field while setting;
// without it blink is constant 0.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic              clk,
  input  logic              a_reset,
  watch_set_ctrl_if.master  bus
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

  ctrl_state_t    r_state;
  ctrl_state_t    w_next;
  logic [PW-1:0]  r_presc;

  bcd_t r_eh_t, r_eh_o, r_em_t, r_em_o;
  bcd_t r_ld_h_t, r_ld_h_o, r_ld_m_t, r_ld_m_o;

  logic w_mode;
  logic w_inc;
  logic w_tick;
  logic w_ld;
  logic w_edit;
  sel_t w_sel;

  bcd_t w_h_t_src, w_h_o_src, w_m_t_src, w_m_o_src;
  bcd_t w_h_t_inc, w_h_o_inc, w_m_t_inc, w_m_o_inc;
  logic w_h_valid, w_m_valid;

  // mode wins over a simultaneous inc
  assign w_mode = bus.mode_p;
  assign w_inc  = bus.inc_p & ~bus.mode_p;

  // In RUN the incrementers only serve as range checkers for the capture;
  // while editing they compute the next value of the edit registers.
  assign w_h_t_src = (r_state == RUN) ? bus.cur_h_t : r_eh_t;
  assign w_h_o_src = (r_state == RUN) ? bus.cur_h_o : r_eh_o;
  assign w_m_t_src = (r_state == RUN) ? bus.cur_m_t : r_em_t;
  assign w_m_o_src = (r_state == RUN) ? bus.cur_m_o : r_em_o;

  bcd2_inc #(.T_MAX(HOUR_T_MAX), .O_WRAP(HOUR_O_WRAP)) u_inc_h (
    .i_t     (w_h_t_src),
    .i_o     (w_h_o_src),
    .o_t     (w_h_t_inc),
    .o_o     (w_h_o_inc),
    .o_valid (w_h_valid)
  );

  bcd2_inc #(.T_MAX(MIN_T_MAX), .O_WRAP(DIGIT_MAX)) u_inc_m (
    .i_t     (w_m_t_src),
    .i_o     (w_m_o_src),
    .o_t     (w_m_t_inc),
    .o_o     (w_m_o_inc),
    .o_valid (w_m_valid)
  );

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    w_ld   = 1'b0;
    w_edit = 1'b0;
    w_sel  = SEL_NONE;
    unique case (r_state)
      RUN: begin
        w_tick = (r_presc == TICK_LAST);
        if (w_mode) w_next = SET_H;
      end
      SET_H: begin
        w_edit = 1'b1;
        w_sel  = SEL_HOURS;
        if (w_mode) w_next = SET_M;
      end
      SET_M: begin
        w_edit = 1'b1;
        w_sel  = SEL_MIN;
        if (w_mode) w_next = COMMIT;
      end
      COMMIT: begin
        w_ld   = 1'b1;
        w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end

  // Prescaler only advances in RUN; any departure from RUN (and the whole
  // edit/commit sequence) leaves it at 0 so the first tick after COMMIT
  // lands on the TICK_DIV-th RUN cycle.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_presc <= '0;
    end else if ((r_state == RUN) && !w_mode) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end else begin
      r_presc <= '0;
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_eh_t <= '0;
      r_eh_o <= '0;
      r_em_t <= '0;
      r_em_o <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mode) begin
            r_eh_t <= w_h_valid ? bus.cur_h_t : '0;
            r_eh_o <= w_h_valid ? bus.cur_h_o : '0;
            r_em_t <= w_m_valid ? bus.cur_m_t : '0;
            r_em_o <= w_m_valid ? bus.cur_m_o : '0;
          end
        end
        SET_H: begin
          if (w_inc) begin
            r_eh_t <= w_h_t_inc;
            r_eh_o <= w_h_o_inc;
          end
        end
        SET_M: begin
          if (w_inc) begin
            r_em_t <= w_m_t_inc;
            r_em_o <= w_m_o_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Load value is latched on the way into COMMIT, so it is valid during
  // the ld cycle and then simply holds.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_ld_h_t <= '0;
      r_ld_h_o <= '0;
      r_ld_m_t <= '0;
      r_ld_m_o <= '0;
    end else if ((r_state == SET_M) && w_mode) begin
      r_ld_h_t <= r_eh_t;
      r_ld_h_o <= r_eh_o;
      r_ld_m_t <= r_em_t;
      r_ld_m_o <= r_em_o;
    end
  end

`ifdef BLINK_EN
  localparam int             BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_bcnt;
  logic          r_blink;

  // Restart the blink phase (visible) on any state change, on every inc,
  // and whenever we are not editing.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if ((w_next != r_state) || w_inc || !w_edit) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_bcnt == BLINK_LAST) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

  assign bus.blink = r_blink;
`else
  // BLINK_DIV has no effect in this build; folding it into a constant 0
  // keeps the parameter referenced.
  localparam logic BLINK_OFF = 1'b0 & (BLINK_DIV > 0);

  assign bus.blink = BLINK_OFF;
`endif

  assign bus.tick   = w_tick;
  assign bus.ld     = w_ld;
  assign bus.edit   = w_edit;
  assign bus.sel    = w_sel;
  assign bus.ld_h_t = r_ld_h_t;
  assign bus.ld_h_o = r_ld_h_o;
  assign bus.ld_m_t = r_ld_m_t;
  assign bus.ld_m_o = r_ld_m_o;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed button sequences, a behavioural model
// of the time-setting rules checked every cycle, and literal expectations
// for the documented scenarios.
`timescale 1ns/1ps
module tb_watch_set_ctrl;
  import watch_pkg::*;

  localparam int TICK_DIV  = 10;
  localparam int BLINK_DIV = 4;

  logic clk = 1'b0;
  logic a_reset;
  always #5 clk = ~clk;

  watch_set_ctrl_if bus();

  watch_set_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk     (clk),
    .a_reset (a_reset),
    .bus     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 run, 1 set hours, 2 set minutes, 3 commit
  int m_mode, m_h, m_m, m_ld_h, m_ld_m, m_runk, m_age;

  function automatic int norm(input int t, input int o, input int maxv);
    if (t > 9 || o > 9 || (t * 10 + o) > maxv) return 0;
    return t * 10 + o;
  endfunction

  always @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      m_mode = 0; m_h = 0; m_m = 0; m_ld_h = 0; m_ld_m = 0; m_runk = 1; m_age = 0;
    end else begin
      case (m_mode)
        0: if (bus.mode_p) begin
             m_h = norm(int'(bus.cur_h_t), int'(bus.cur_h_o), 23);
             m_m = norm(int'(bus.cur_m_t), int'(bus.cur_m_o), 59);
             m_mode = 1; m_age = 0;
           end else m_runk++;
        1: if (bus.mode_p) begin m_mode = 2; m_age = 0; end
           else if (bus.inc_p) begin m_h = (m_h + 1) % 24; m_age = 0; end
           else m_age++;
        2: if (bus.mode_p) begin m_mode = 3; m_ld_h = m_h; m_ld_m = m_m; end
           else if (bus.inc_p) begin m_m = (m_m + 1) % 60; m_age = 0; end
           else m_age++;
        default: begin m_mode = 0; m_runk = 1; end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int         ld_cnt = 0;
  logic [1:0] prev_sel = 2'd0;
  logic [1:0] sel_q[$];

  always @(negedge clk) begin
    if (a_reset === 1'b0) begin
      logic [15:0] exp_ld;
      logic        exp_blink;
      exp_ld = {4'(m_ld_h / 10), 4'(m_ld_h % 10), 4'(m_ld_m / 10), 4'(m_ld_m % 10)};
`ifdef BLINK_EN
      exp_blink = (m_mode == 1 || m_mode == 2) ? 1'((m_age / BLINK_DIV) % 2) : 1'b0;
`else
      exp_blink = 1'b0;
`endif
      check("tick",  bus.tick, (m_mode == 0 && (m_runk % TICK_DIV) == 0) ? 1 : 0);
      check("ld",    bus.ld,   (m_mode == 3) ? 1 : 0);
      check("ld_val", {bus.ld_h_t, bus.ld_h_o, bus.ld_m_t, bus.ld_m_o}, exp_ld);
      check("edit",  bus.edit, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      check("sel",   bus.sel,  (m_mode == 1 || m_mode == 2) ? m_mode : 0);
      check("blink", bus.blink, exp_blink);
    end
    if (bus.ld === 1'b1) ld_cnt++;
    if (bus.sel !== prev_sel) begin
      sel_q.push_back(bus.sel);
      prev_sel = bus.sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i);
    bus.mode_p = m;
    bus.inc_p  = i;
    step();
    bus.mode_p = 1'b0;
    bus.inc_p  = 1'b0;
  endtask

  task automatic set_cur(input logic [15:0] v);
    {bus.cur_h_t, bus.cur_h_o, bus.cur_m_t, bus.cur_m_o} = v;
  endtask

  function automatic logic [15:0] ld_now();
    return {bus.ld_h_t, bus.ld_h_o, bus.ld_m_t, bus.ld_m_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got stuck, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    int tick_q[$];
    int k;
    int ld0;
    logic b[12];

    bus.mode_p = 1'b0;
    bus.inc_p  = 1'b0;
    set_cur(16'h0000);
    a_reset = 1'b0;
    #1 a_reset = 1'b1;
    repeat (3) step();
    check("rst_edit", bus.edit, 0);
    check("rst_sel",  bus.sel, 0);
    check("rst_ld",   {bus.ld, ld_now()}, 0);
    check("rst_tick", bus.tick, 0);

    // 1: free run, ticks on cycles 10, 20, 30
    a_reset = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (bus.tick === 1'b1) tick_q.push_back(c);
      step();
    end
    check("t1_ntick", tick_q.size(), 3);
    if (tick_q.size() == 3) begin
      check("t1_tick0", tick_q[0], 10);
      check("t1_tick1", tick_q[1], 20);
      check("t1_tick2", tick_q[2], 30);
    end
    check("t1_ldcnt", ld_cnt, 0);

    // 2: 19:58 -> +5h -> +3m -> 00:01
    set_cur(16'h1958);
    sel_q.delete();
    ld0 = ld_cnt;
    pulse(1, 0);
    repeat (5) pulse(0, 1);
    pulse(1, 0);
    repeat (3) pulse(0, 1);
    pulse(1, 0);
    check("t2_ld",     bus.ld, 1);
    check("t2_ldval",  ld_now(), 16'h0001);
    check("t2_nsel",   sel_q.size(), 3);
    if (sel_q.size() == 3) begin
      check("t2_sel0", sel_q[0], 1);
      check("t2_sel1", sel_q[1], 2);
      check("t2_sel2", sel_q[2], 0);
    end
    k = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (bus.tick === 1'b1) begin k = c; break; end
    end
    check("t2_tick_after", k, 10);
    check("t2_ldcnt", ld_cnt - ld0, 1);

    // 3: invalid capture normalises to 00:00
    set_cur(16'h2A77);
    pulse(1, 0);
    pulse(1, 0);
    pulse(1, 0);
    check("t3_ld",    bus.ld, 1);
    check("t3_ldval", ld_now(), 16'h0000);
    step();

    // 4: simultaneous mode+inc in SET_H; inc in RUN ignored
    set_cur(16'h0845);
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 1);
    check("t4_sel", bus.sel, 2);
    pulse(1, 0);
    check("t4_ldval", ld_now(), 16'h0945);
    step();
    pulse(0, 1);
    check("t4_run_edit", bus.edit, 0);
    check("t4_run_sel",  bus.sel, 0);
    repeat (3) step();

    // 5: reset during SET_M with 12:34 being edited
    set_cur(16'h1133);
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    pulse(0, 1);
    step();
    ld0 = ld_cnt;
    a_reset = 1'b1;
    #1;
    check("t5_edit", bus.edit, 0);
    check("t5_sel",  bus.sel, 0);
    check("t5_ld",   {bus.ld, ld_now()}, 0);
    step();
    step();
    a_reset = 1'b0;
    k = 0;
    for (int c = 2; c <= 25; c++) begin
      step();
      if (bus.tick === 1'b1) begin k = c; break; end
    end
    check("t5_tick_after", k, 10);
    check("t5_ldcnt", ld_cnt - ld0, 0);

    // 6: blink behaviour in SET_H
    set_cur(16'h0715);
    pulse(1, 0);
    for (int i = 0; i < 12; i++) begin
      b[i] = bus.blink;
      step();
    end
    pulse(0, 1);
    check("t6_blink_inc", bus.blink, 0);
    repeat (4) step();
`ifdef BLINK_EN
    for (int i = 0; i < 12; i++)
      check("t6_blink_pat", b[i], (i >= 4 && i < 8) ? 1 : 0);
    check("t6_blink_restart", bus.blink, 1);
`else
    for (int i = 0; i < 12; i++)
      check("t6_blink_off", b[i], 0);
    check("t6_blink_restart", bus.blink, 0);
`endif
    pulse(1, 0);
    pulse(1, 0);
    check("t6_blink_commit", bus.blink, 0);
    check("t6_ldval", ld_now(), 16'h0815);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
